// File: rtl/crypto_sha256_stream_top.sv
// Wishbone-mapped SHA-256 streamer: buffers 512-bit blocks and feeds a one-round-per-cycle core.
// Optional completion interrupt (irq_o) is built only when CRYPTO_SHA256_IRQ_EN is defined.

module sha256_core (
  input  logic         clk,
  input  logic         load_i,
  input  logic [511:0] data_i,
  input  logic [255:0] state_i,
  output logic [255:0] state_o,
  output logic         busy_o
);
  localparam logic [63:0][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // Working variables: index 7 = a ... index 0 = h; w_q[15] is the current schedule word.
  logic [7:0][31:0]  hin_q, v_q, v_d;
  logic [15:0][31:0] w_q;
  logic [31:0]       w_new;
  logic [5:0]        t_q;
  logic              busy_q;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One compression round plus the next message-schedule word.
  always_comb begin
    logic [31:0] s1, ch, t1, s0, maj;
    s1    = rotr(v_q[3], 6) ^ rotr(v_q[3], 11) ^ rotr(v_q[3], 25);
    ch    = (v_q[3] & v_q[2]) ^ (~v_q[3] & v_q[1]);
    t1    = v_q[0] + s1 + ch + K[6'd63 - t_q] + w_q[15];
    s0    = rotr(v_q[7], 2) ^ rotr(v_q[7], 13) ^ rotr(v_q[7], 22);
    maj   = (v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]);
    v_d   = {t1 + s0 + maj, v_q[7], v_q[6], v_q[5], v_q[4] + t1, v_q[3], v_q[2], v_q[1]};
    w_new = (rotr(w_q[1], 17) ^ rotr(w_q[1], 19) ^ (w_q[1] >> 10)) + w_q[6]
          + (rotr(w_q[14], 7) ^ rotr(w_q[14], 18) ^ (w_q[14] >> 3)) + w_q[15];
  end

  // Load a block or advance one round; busy drops after round 63.
  always_ff @(posedge clk) begin
    if (load_i) begin
      hin_q  <= state_i;
      v_q    <= state_i;
      w_q    <= data_i;
      t_q    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      v_q <= v_d;
      w_q <= {w_q[14:0], w_new};
      t_q <= t_q + 6'd1;
      if (t_q == 6'd63) busy_q <= 1'b0;
    end
  end

  // Feed-forward sum of the chaining input and the final working variables.
  always_comb begin
    for (int i = 0; i < 8; i++) state_o[i*32 +: 32] = hin_q[i] + v_q[i];
  end

  assign busy_o = busy_q;
endmodule

module crypto_sha256_stream_top #(
  parameter int unsigned NUM_BLOCKS = 2,
  parameter int unsigned AW         = 7
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_bte_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
`ifdef CRYPTO_SHA256_IRQ_EN
  output logic        irq_o,
`endif
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [31:0] wb_dat_o
);
  localparam int unsigned SW  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned WAW = AW - 2;
  localparam logic [7:0][31:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {IDLE, LOAD, WAITB, RUN, UPD} seq_e;

  seq_e              state_q, state_d;
  logic [3:0]        queued_q, queued_d, widx_q, widx_d;
  logic [SW-1:0]     head_q, head_d, wslot_q, wslot_d;
  logic [7:0][31:0]  chain_q, chain_d;
  logic              done_q, done_d, irq_en_q, irq_en_d;
  logic              ack_q, ack_d, err_q, err_d;
  logic [31:0]       dat_q, dat_d;
  logic [15:0][31:0] buf_q [2**SW];
  logic              load_c, busy_c, full_c, req_c, buf_we_c, commit_c, upd_c, core_busy;
  logic [WAW-1:0]    wa_c;
  logic [255:0]      core_state;
  logic              unused_ok;

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SW'(NUM_BLOCKS - 1)) ? '0 : s + SW'(1);
  endfunction

  assign req_c  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign wa_c   = wb_adr_i[AW-1:2];
  assign upd_c  = (state_q == UPD);
  assign busy_c = (state_q != IDLE) || (queued_q != 4'd0);
  assign full_c = (queued_q == 4'(NUM_BLOCKS));

  sha256_core u_core (
    .clk     (wb_clk_i),
    .load_i  (load_c),
    .data_i  (buf_q[head_q]),
    .state_i (chain_q),
    .state_o (core_state),
    .busy_o  (core_busy)
  );

  // Sequencer next state; load pulses for the single LOAD cycle.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE:    if (queued_q != 4'd0) state_d = LOAD;
      LOAD:    begin load_c = 1'b1; state_d = WAITB; end
      WAITB:   if (core_busy) state_d = RUN;
      RUN:     if (!core_busy) state_d = UPD;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus decode, block buffering and chain/DONE update.
  always_comb begin
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = '0;
    widx_d   = widx_q;
    wslot_d  = wslot_q;
    head_d   = head_q;
    chain_d  = chain_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    buf_we_c = 1'b0;
    commit_c = 1'b0;
    if (req_c) begin
      if (!wb_we_i) begin
        ack_d = 1'b1;
        if (wa_c == WAW'(0))      dat_d = {30'h0, irq_en_q, 1'b0};
        else if (wa_c == WAW'(1)) dat_d = {16'h0, widx_q, queued_q, 5'h0, done_q, full_c, busy_c};
        else if ((wa_c >> 3) == WAW'(1)) dat_d = chain_q[3'(7) - wa_c[2:0]];
      end else if (wa_c == WAW'(0)) begin
        if (wb_dat_i[0] && (busy_c || widx_q != 4'd0)) begin
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          if (wb_dat_i[0]) begin
            chain_d = IV;
            done_d  = 1'b0;
          end
`ifdef CRYPTO_SHA256_IRQ_EN
          irq_en_d = wb_dat_i[1];
          if (wb_dat_i[2]) done_d = 1'b0;
`endif
        end
      end else if (wa_c == WAW'(2)) begin
        if (full_c) begin
          err_d = 1'b1;
        end else begin
          ack_d    = 1'b1;
          buf_we_c = 1'b1;
          done_d   = 1'b0;
          if (widx_q == 4'd15) begin
            widx_d   = 4'd0;
            commit_c = 1'b1;
            wslot_d  = slot_inc(wslot_q);
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end
      end else begin
        ack_d = 1'b1;
      end
    end
    if (upd_c) begin
      chain_d = core_state;
      head_d  = slot_inc(head_q);
      done_d  = 1'b1;
    end
    queued_d = queued_q + 4'(commit_c) - 4'(upd_c);
  end

  // Control and bus-response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      queued_q <= '0;
      widx_q   <= '0;
      head_q   <= '0;
      wslot_q  <= '0;
      chain_q  <= IV;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      queued_q <= queued_d;
      widx_q   <= widx_d;
      head_q   <= head_d;
      wslot_q  <= wslot_d;
      chain_q  <= chain_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
    end
  end

  // Message buffer: word 0 lands in the top 32 bits of its slot.
  always_ff @(posedge wb_clk_i) begin
    if (buf_we_c) buf_q[wslot_q][4'd15 - widx_q] <= wb_dat_i;
  end

`ifdef CRYPTO_SHA256_IRQ_EN
  logic irq_q;
  // Registered interrupt level follows the next DONE and IRQ_EN values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) irq_q <= 1'b0;
    else             irq_q <= done_d & irq_en_d;
  end
  assign irq_o = irq_q;
`endif

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_rty_o  = 1'b0;
  assign wb_dat_o  = dat_q;
  assign unused_ok = ^{wb_adr_i[31:AW], wb_adr_i[1:0], wb_sel_i, wb_bte_i, wb_cti_i};
endmodule

// File: tb/tb_crypto_sha256_stream_top.sv
// Bench for crypto_sha256_stream_top: two instances (NUM_BLOCKS=2 and 1) on a muxed bus,
// fixed SHA-256 vectors plus random block streams checked against a reference compression model.
`timescale 1ns/1ps
module tb_crypto_sha256_stream_top;
  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_DATA = 32'h08, A_DIG = 32'h20;
  localparam logic [255:0] IV_V  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] b_adr, b_dat;
  logic [3:0]  b_sel;
  logic        b_we, b_cyc, b_stb, dsel;
  logic [1:0]  b_bte;
  logic [2:0]  b_cti;
  logic        ack2, err2, rty2, ack1, err1, rty1;
  logic [31:0] dat2, dat1;
  logic        m_ack, m_err, m_rty;
  logic [31:0] m_dat;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign m_ack = dsel ? ack1 : ack2;
  assign m_err = dsel ? err1 : err2;
  assign m_rty = dsel ? rty1 : rty2;
  assign m_dat = dsel ? dat1 : dat2;

`ifdef CRYPTO_SHA256_IRQ_EN
  logic irq2, irq1, m_irq;
  assign m_irq = dsel ? irq1 : irq2;
`endif

  crypto_sha256_stream_top #(.NUM_BLOCKS(2), .AW(7)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel),
    .wb_we_i(b_we), .wb_bte_i(b_bte), .wb_cti_i(b_cti), .wb_cyc_i(b_cyc & ~dsel), .wb_stb_i(b_stb & ~dsel),
`ifdef CRYPTO_SHA256_IRQ_EN
    .irq_o(irq2),
`endif
    .wb_ack_o(ack2), .wb_err_o(err2), .wb_rty_o(rty2), .wb_dat_o(dat2));

  crypto_sha256_stream_top #(.NUM_BLOCKS(1), .AW(7)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel),
    .wb_we_i(b_we), .wb_bte_i(b_bte), .wb_cti_i(b_cti), .wb_cyc_i(b_cyc & dsel), .wb_stb_i(b_stb & dsel),
`ifdef CRYPTO_SHA256_IRQ_EN
    .irq_o(irq1),
`endif
    .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1), .wb_dat_o(dat1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: SHA-256 compression from the textbook definition.
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return r;
  endfunction

  // One classic cycle: response must arrive after exactly one clock and last one clock.
  task automatic bus_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic ack, output logic err);
    int n;
    @(posedge clk); #1;
    b_adr = a; b_dat = d; b_we = we; b_cyc = 1'b1; b_stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(m_ack || m_err) && n < 8);
    ack = m_ack; err = m_err; rd = m_dat;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    chk("bus_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    chk("bus_pulse", {30'h0, m_ack, m_err}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_err, input string nm);
    logic [31:0] rd;
    logic ack, err;
    bus_xfer(1'b1, a, d, rd, ack, err);
    chk(nm, {30'h0, ack, err}, exp_err ? 32'h1 : 32'h2);
  endtask

  task automatic rdreg(input logic [31:0] a, output logic [31:0] d);
    logic ack, err;
    bus_xfer(1'b0, a, 32'h0, d, ack, err);
    chk("read_ack", {30'h0, ack, err}, 32'h2);
  endtask

  task automatic feed_block(input logic [511:0] blk, input string nm);
    for (int i = 0; i < 16; i++) wr(A_DATA, blk[511-32*i -: 32], 1'b0, nm);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n = 0;
    do begin
      rdreg(A_STAT, s);
      n++;
    end while (s[0] && n < 400);
    chk("idle_timeout", {31'h0, s[0]}, 32'h0);
  endtask

  task automatic chk_digest(input string nm, input logic [255:0] exp);
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      rdreg(A_DIG + 32'(4 * i), d);
      chk($sformatf("%s_H%0d", nm, i), d, exp[255-32*i -: 32]);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        rst_tab [12];
    logic [31:0] s, rd;
    logic [511:0] blk;
    logic [255:0] model;
    logic        ack, err;
    int          nb, tries;

    rst_tab[0]  = '{"rst_ctrl", A_CTRL, 32'h0};
    rst_tab[1]  = '{"rst_status", A_STAT, 32'h0};
    for (int i = 0; i < 8; i++) rst_tab[2+i] = '{$sformatf("rst_H%0d", i), A_DIG + 32'(4 * i), IV_V[255-32*i -: 32]};
    rst_tab[10] = '{"rst_unmapped40", 32'h40, 32'h0};
    rst_tab[11] = '{"rst_unmapped0c", 32'h0c, 32'h0};

    rst_n = 1'b0; dsel = 1'b0;
    b_adr = '0; b_dat = '0; b_sel = 4'hf; b_we = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
    b_bte = 2'b00; b_cti = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_out", {m_dat[29:0], m_ack, m_err}, 32'h0);
    rst_n = 1'b1;

    // Reset state table.
    for (int i = 0; i < 12; i++) begin
      rdreg(rst_tab[i].adr, rd);
      chk(rst_tab[i].name, rd, rst_tab[i].exp);
    end
    chk("rty_tied", {31'h0, m_rty}, 32'h0);

    // "abc": partial-word index, busy, INIT rejected while busy, then digest.
    wr(A_CTRL, 32'h1, 1'b0, "abc_init");
    for (int i = 0; i < 16; i++) begin
      wr(A_DATA, ABC_B[511-32*i -: 32], 1'b0, "abc_data");
      if (i == 2) begin
        rdreg(A_STAT, s);
        chk("status_widx3", s, 32'h00003000);
      end
    end
    rdreg(A_STAT, s);
    chk("abc_status_busy", s, 32'h00000101);
    wr(A_CTRL, 32'h1, 1'b1, "init_while_busy");
    wait_idle();
    rdreg(A_STAT, s);
    chk("abc_status_done", s, 32'h00000004);
    chk_digest("abc", ABC_D);
    rdreg(32'h40, rd);
    chk("read_40", rd, 32'h0);
    wr(32'h44, 32'hffffffff, 1'b0, "wr_unmapped");
    rdreg(A_STAT, s);
    chk("unmapped_no_effect", s, 32'h00000004);

    // Two-block message streamed back to back.
    wr(A_CTRL, 32'h1, 1'b0, "two_init");
    rdreg(A_STAT, s);
    chk("init_clears_done", s, 32'h0);
    feed_block(TWO_B1, "two_b1");
    feed_block(TWO_B2, "two_b2");
    wait_idle();
    chk_digest("two", TWO_D);

    // Single-slot buffer: word written while full is rejected and dropped.
    dsel = 1'b1;
    wr(A_CTRL, 32'h1, 1'b0, "nb1_init");
    feed_block(ABC_B, "nb1_data");
    rdreg(A_STAT, s);
    chk("nb1_status_full", s, 32'h00000103);
    wr(A_DATA, 32'hdeadbeef, 1'b1, "nb1_full_err");
    rdreg(A_STAT, s);
    chk("nb1_dropped_widx", s, 32'h00000103);
    wait_idle();
    rdreg(A_STAT, s);
    chk("nb1_done", s, 32'h00000004);
    chk_digest("nb1", ABC_D);
    dsel = 1'b0;

    // Random block streams against the reference model.
    for (int it = 0; it < 3; it++) begin
      nb = $urandom_range(1, 3);
      model = IV_V;
      wr(A_CTRL, 32'h1, 1'b0, "rnd_init");
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom();
        model = ref_compress(model, blk);
        for (int i = 0; i < 16; i++) begin
          tries = 0;
          do begin
            bus_xfer(1'b1, A_DATA, blk[511-32*i -: 32], rd, ack, err);
            if (err) repeat (10) @(posedge clk);
            tries++;
          end while (err && tries < 50);
          chk("rnd_data_accept", {31'h0, ack}, 32'h1);
        end
      end
      wait_idle();
      chk_digest($sformatf("rnd%0d", it), model);
    end

`ifdef CRYPTO_SHA256_IRQ_EN
    // Interrupt raise on completion and clear by IRQ_CLR.
    wr(A_CTRL, 32'h3, 1'b0, "irq_init");
    chk("irq_low_after_init", {31'h0, m_irq}, 32'h0);
    feed_block(ABC_B, "irq_data");
    tries = 0;
    while (!m_irq && tries < 400) begin
      @(posedge clk); #1;
      tries++;
    end
    chk("irq_rise", {31'h0, m_irq}, 32'h1);
    rdreg(A_CTRL, rd);
    chk("irq_en_read", rd, 32'h2);
    wr(A_CTRL, 32'h6, 1'b0, "irq_clr");
    chk("irq_cleared", {31'h0, m_irq}, 32'h0);
`endif

    // Reset in the middle of a hash: everything returns to the IV/empty state.
    wr(A_CTRL, 32'h1, 1'b0, "mid_init");
    for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom();
    feed_block(blk, "mid_data");
    wr(A_DATA, 32'h12345678, 1'b0, "mid_partial");
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus", {30'h0, m_ack, m_err}, 32'h0);
`ifdef CRYPTO_SHA256_IRQ_EN
    chk("mid_rst_irq", {31'h0, m_irq}, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdreg(A_STAT, s);
    chk("mid_rst_status", s, 32'h0);
    chk_digest("mid_rst_iv", IV_V);
    feed_block(ABC_B, "post_rst_data");
    wait_idle();
    chk_digest("post_rst_abc", ABC_D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crypto_sha256_stream_top.md
CRYPTO_SHA256_STREAM_TOP -- requirements
Module: crypto_sha256_stream_top

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 2, meaning the number of 512-bit message blocks buffered (1..8).
REQ-002 SHALL have parameter AW, default 7, meaning the number of decoded Wishbone address bits (byte address).
REQ-003 SHALL have port wb_clk_i  in  1  meaning the single clock for bus, buffer, sequencer and core; there is one clock, no CDC.
REQ-004 SHALL have port wb_rst_n_i  in  1  meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have ports wb_adr_i in 32, wb_dat_i in 32, wb_sel_i in 4, wb_we_i in 1, wb_bte_i in 2, wb_cti_i in 3, wb_cyc_i in 1, wb_stb_i in 1, meaning the Wishbone slave inputs; only adr[AW-1:2] are decoded.
REQ-006 SHALL have ports wb_ack_o out 1, wb_err_o out 1, wb_rty_o out 1, wb_dat_o out 32, meaning the Wishbone slave outputs.
REQ-007 SHALL have port irq_o  out  1  meaning the completion interrupt; this port is present only with CRYPTO_SHA256_IRQ_EN.

Function
REQ-008 SHALL instantiate sha256_core (clk, load_i, data_i[511:0], state_i[255:0], state_o[255:0], busy_o) clocked by wb_clk_i.
REQ-009 SHALL decode this register map: 0x00 CTRL (W: bit0 INIT, bit1 IRQ_EN, bit2 IRQ_CLR); 0x04 STATUS (R: bit0 BUSY, bit1 FULL, bit2 DONE, [11:8] blocks queued, [15:12] current word index); 0x08 DATA (W: message word); 0x20..0x3C DIGEST H0..H7 (R).
REQ-010 SHALL assert exactly one of wb_ack_o or wb_err_o for one cycle, one cycle after cyc&stb rises, and SHALL hold them low otherwise; wb_rty_o is tied 0; cti/bte are ignored, so every access is treated as classic.
REQ-011 SHALL ack unmapped addresses, with reads returning 0 and writes having no effect; wb_sel_i is ignored, so all writes are full-word.
REQ-012 SHALL place DATA writes big-endian, so that word 0 of a block maps to data_i[511:480] and word 15 maps to data_i[31:0].
REQ-013 SHALL commit a block after its 16th word; the queued count increments, the word index wraps to 0, and the write slot advances modulo NUM_BLOCKS.
REQ-014 SHALL, on a DATA write while FULL (queued == NUM_BLOCKS), return wb_err_o and drop the word with no state change.
REQ-015 SHALL hold the 256-bit chain register with H0 in [255:224]; INIT loads the SHA-256 IV (6a09e667 ... 5be0cd19) and clears DONE.
REQ-016 SHALL, on an INIT write while BUSY or while queued != 0 or word index != 0, return wb_err_o and ignore the INIT.
REQ-017 SHALL implement the sequencer FSM states IDLE, LOAD, WAITB, RUN and UPD.
REQ-018 SHALL transition IDLE->LOAD when queued > 0; in LOAD it drives load_i=1 for one cycle with data_i = the head block and state_i = chain.
REQ-019 SHALL transition LOAD->WAITB, and WAITB->RUN when busy_o=1.
REQ-020 SHALL transition RUN->UPD when busy_o=0, and in UPD capture state_o into chain, decrement queued, advance the head modulo NUM_BLOCKS, set DONE, and return to IDLE.
REQ-021 SHALL, when a block commit (REQ-013) and UPD occur in the same cycle, leave queued unchanged, and FULL SHALL reflect the result.
REQ-022 SHALL drive BUSY=1 in any state other than IDLE, and BUSY=1 in IDLE when queued>0.
REQ-023 SHALL have DIGEST reads return the chain register at all times; values are valid only when BUSY=0.
REQ-024 SHALL clear DONE on writes of INIT, IRQ_CLR or DATA.

Reset
REQ-025 SHALL, on wb_rst_n_i low, asynchronously force: FSM=IDLE; queued, word index, head and write slot = 0; chain = IV; DONE=0; IRQ_EN=0; wb_ack_o=wb_err_o=0; wb_dat_o=0; load_i=0; irq_o=0.
REQ-026 SHALL, on reset asserted mid-hash, discard the buffered blocks and the partial block; the core's busy_o is ignored until the FSM re-enters LOAD.

Configuration
REQ-027 SHALL, with CRYPTO_SHA256_IRQ_EN defined, present irq_o as a registered level = DONE & IRQ_EN, cleared by IRQ_CLR or INIT.
REQ-028 SHALL, without CRYPTO_SHA256_IRQ_EN, omit irq_o, hold CTRL bit1 and bit2 writes without effect, and read IRQ_EN as 0.

Verification
REQ-029 The bench SHALL cover: reset -> STATUS=0x0, DIGEST H0=0x6a09e667, H7=0x5be0cd19, ack/err low.
REQ-030 The bench SHALL cover: INIT, then 16 DATA words of padded "abc" (0x61626380, 0 x14, 0x00000018) -> BUSY then DONE; DIGEST = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-031 The bench SHALL cover: INIT, then 32 back-to-back words of padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with NUM_BLOCKS=2 -> no err; DIGEST = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-032 The bench SHALL cover: NUM_BLOCKS=1 with the core held busy, then the 17th word written while FULL -> wb_err_o=1 for one cycle, the word is dropped, and the final digest is unaffected.
REQ-033 The bench SHALL cover: INIT written while BUSY=1 -> wb_err_o=1, chain unchanged; a read of address 0x40 -> ack, data 0.
REQ-034 The bench SHALL cover: with CRYPTO_SHA256_IRQ_EN and IRQ_EN=1, block completion -> irq_o=1 the cycle after UPD; IRQ_CLR -> irq_o=0 next cycle; wb_rst_n_i pulsed low mid-RUN -> STATUS=0 and chain=IV immediately.
